// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller: ALU operation codes,
// opcode/funct values, FSM states and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // Instruction class: decides the path the FSM takes after EXEC.
    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_LOAD   = 3'd1,
        K_STORE  = 3'd2,
        K_BRANCH = 3'd3,
        K_JUMP   = 3'd4,
        K_JAL    = 3'd5
    } kind_t;

    typedef struct packed {
        logic [5:0] alufun;
        logic       sign;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsrc;
        kind_t      kind;
        logic       dest_nz;
    } ctrl_t;

    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c      = '0;
        c.sign = 1'b1;
        c.kind = K_ALU;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-to-control mapping; flags any opcode/funct outside the
// supported subset as illegal.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    ctrl_t      c;
    logic       unused_fields;

    assign op            = instr_i[31:26];
    assign rt            = instr_i[20:16];
    assign rd            = instr_i[15:11];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        c         = ctrl_default();
        illegal_o = 1'b0;
        case (op)
            OP_RTYPE: begin
                c.regdst = 2'd1;
                case (funct)
                    FN_ADD:  c.alufun = ALU_ADD;
                    FN_ADDU: begin c.alufun = ALU_ADD; c.sign = 1'b0; end
                    FN_SUB:  c.alufun = ALU_SUB;
                    FN_SUBU: begin c.alufun = ALU_SUB; c.sign = 1'b0; end
                    FN_AND:  c.alufun = ALU_AND;
                    FN_OR:   c.alufun = ALU_OR;
                    FN_XOR:  c.alufun = ALU_XOR;
                    FN_NOR:  c.alufun = ALU_NOR;
                    FN_SLT:  c.alufun = ALU_LT;
                    FN_SLTU: begin c.alufun = ALU_LT; c.sign = 1'b0; end
                    FN_SLL:  begin c.alufun = ALU_SLL; c.srca = 2'd1; end
                    FN_SRL:  begin c.alufun = ALU_SRL; c.srca = 2'd1; end
                    FN_SRA:  begin c.alufun = ALU_SRA; c.srca = 2'd1; end
                    FN_JR: begin
                        c.kind   = K_JUMP;
                        c.pcsrc  = 2'd2;
                        c.regdst = 2'd0;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI:  begin c.alufun = ALU_ADD; c.srcb = 2'd1; end
            OP_ADDIU: begin c.alufun = ALU_ADD; c.srcb = 2'd1; c.sign = 1'b0; end
            OP_SLTI:  begin c.alufun = ALU_LT;  c.srcb = 2'd1; end
            OP_SLTIU: begin c.alufun = ALU_LT;  c.srcb = 2'd1; c.sign = 1'b0; end
            OP_ANDI:  begin c.alufun = ALU_AND; c.srcb = 2'd2; end
            // lui is a shift of the zero-extended immediate left by the constant 16.
            OP_LUI: begin
                c.alufun = ALU_SLL;
                c.srca   = 2'd2;
                c.srcb   = 2'd2;
            end
            OP_LW: begin
                c.alufun   = ALU_ADD;
                c.srcb     = 2'd1;
                c.memtoreg = 2'd1;
                c.kind     = K_LOAD;
            end
            OP_SW: begin
                c.alufun = ALU_ADD;
                c.srcb   = 2'd1;
                c.kind   = K_STORE;
            end
            OP_BEQ:  begin c.alufun = ALU_EQ;  c.kind = K_BRANCH; end
            OP_BNE:  begin c.alufun = ALU_NEQ; c.kind = K_BRANCH; end
            OP_BLEZ: begin c.alufun = ALU_LEZ; c.srcb = 2'd3; c.kind = K_BRANCH; end
            OP_BGTZ: begin c.alufun = ALU_GTZ; c.srcb = 2'd3; c.kind = K_BRANCH; end
            OP_REGIMM: begin
                if (rt == 5'd0) begin
                    c.alufun = ALU_LTZ;
                    c.srcb   = 2'd3;
                    c.kind   = K_BRANCH;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_J: begin c.kind = K_JUMP; c.pcsrc = 2'd1; end
            OP_JAL: begin
                c.kind     = K_JAL;
                c.pcsrc    = 2'd1;
                c.regdst   = 2'd2;
                c.memtoreg = 2'd2;
            end
            default: illegal_o = 1'b1;
        endcase

        case (c.regdst)
            2'd1:    c.dest_nz = (rd != 5'd0);
            2'd2:    c.dest_nz = 1'b1;
            default: c.dest_nz = (rt != 5'd0);
        endcase
        ctrl_o = c;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB), with a
// saturating memory wait counter and a sticky FAULT state left only by reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_z0,
    output logic [5:0]  ALUFun,
    output logic        Sign,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  PCSrc,
    output logic        fault
);

    localparam int              WW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0]   WAIT_MAX  = WW'(MEM_TIMEOUT);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   instr_q;
    ctrl_t         ctrl_q;
    ctrl_t         dec_ctrl;
    logic          dec_illegal;

    ctrl_decode u_decode (
        .instr_i   (instr_q),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Datapath-side registers carry no reset; they are only read in states that follow a write.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && instr_valid) begin
            instr_q <= instr;
        end
        if (state_q == S_DECODE) begin
            ctrl_q <= dec_ctrl;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        instr_ready = 1'b0;
        ALUFun      = '0;
        Sign        = 1'b0;
        ALUSrcA     = '0;
        ALUSrcB     = '0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        PCWrite     = 1'b0;
        RegDst      = '0;
        MemtoReg    = '0;
        PCSrc       = '0;
        fault       = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_illegal ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                ALUFun  = ctrl_q.alufun;
                Sign    = ctrl_q.sign;
                ALUSrcA = ctrl_q.srca;
                ALUSrcB = ctrl_q.srcb;
                PCSrc   = ctrl_q.pcsrc;
                case (ctrl_q.kind)
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_ALU:           state_d = S_WB;
                    K_JAL: begin
                        PCWrite = 1'b1;
                        state_d = S_WB;
                    end
                    K_JUMP: begin
                        PCWrite = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        PCWrite = alu_z0;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                MemRead  = (ctrl_q.kind == K_LOAD);
                MemWrite = (ctrl_q.kind == K_STORE);
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WW'(1);
                end
                if (mem_ready) begin
                    state_d = (ctrl_q.kind == K_LOAD) ? S_WB : S_IDLE;
                end else if (wait_q >= WAIT_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                RegWrite = ctrl_q.dest_nz;
                RegDst   = ctrl_q.regdst;
                MemtoReg = ctrl_q.memtoreg;
                state_d  = S_IDLE;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_MEM && state_q != S_MEM) begin
            wait_d = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_z0;
    logic [5:0]  ALUFun;
    logic        Sign;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic        RegWrite, MemRead, MemWrite, PCWrite;
    logic [1:0]  RegDst, MemtoReg, PCSrc;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .alu_z0      (alu_z0),
        .ALUFun      (ALUFun),
        .Sign        (Sign),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .PCWrite     (PCWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .PCSrc       (PCSrc),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Handshake in the current IDLE cycle; returns at the start of the DECODE cycle.
    task automatic issue(input string t, input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        smp();
        chk({t, "_idle_ready"}, instr_ready, 1);
        adv();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    // Checks the DECODE cycle and returns at the start of the EXEC cycle.
    task automatic to_exec(input string t);
        smp();
        chk({t, "_dec_ready"}, instr_ready, 0);
        chk({t, "_dec_pcwrite"}, PCWrite, 0);
        adv();
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        mem_ready   = 1'b0;
        alu_z0      = 1'b0;
        repeat (2) adv();
        smp();
        chk("rst_ready", instr_ready, 1);
        chk("rst_fault", fault, 0);
        chk("rst_outs", {ALUFun, Sign, ALUSrcA, ALUSrcB, RegWrite, MemRead, MemWrite,
                         PCWrite, RegDst, MemtoReg, PCSrc}, 0);
        adv();
        reset = 1'b0;

        // add $3,$1,$2
        issue("add", rtype(5'd1, 5'd2, 5'd3, 6'h20));
        to_exec("add");
        smp();
        chk("add_exec_alufun", ALUFun, 6'b000000);
        chk("add_exec_sign", Sign, 1);
        chk("add_exec_regwrite", RegWrite, 0);
        adv();
        smp();
        chk("add_wb_regwrite", RegWrite, 1);
        chk("add_wb_regdst", RegDst, 1);
        adv();
        smp();
        chk("add_c4_ready", instr_ready, 1);
        chk("add_c4_regwrite", RegWrite, 0);
        adv();

        // lw $5,4($1) with mem_ready on the 4th MEM cycle
        issue("lw", itype(6'h23, 5'd1, 5'd5, 16'd4));
        to_exec("lw");
        smp();
        chk("lw_exec_alufun", ALUFun, 6'b000000);
        chk("lw_exec_srcb", ALUSrcB, 1);
        chk("lw_exec_memread", MemRead, 0);
        adv();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            smp();
            chk("lw_mem_memread", MemRead, 1);
            adv();
        end
        mem_ready = 1'b0;
        smp();
        chk("lw_wb_memread", MemRead, 0);
        chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        chk("lw_wb_regdst", RegDst, 0);
        adv();
        smp();
        chk("lw_done_ready", instr_ready, 1);
        adv();

        // beq taken, then bne not taken
        alu_z0 = 1'b1;
        issue("beq", itype(6'h04, 5'd1, 5'd2, 16'd8));
        to_exec("beq");
        smp();
        chk("beq_alufun", ALUFun, 6'b110011);
        chk("beq_pcwrite", PCWrite, 1);
        chk("beq_pcsrc", PCSrc, 0);
        adv();
        smp();
        chk("beq_after_pcwrite", PCWrite, 0);
        chk("beq_after_ready", instr_ready, 1);
        adv();
        alu_z0 = 1'b0;
        issue("bne", itype(6'h05, 5'd1, 5'd2, 16'd8));
        to_exec("bne");
        smp();
        chk("bne_alufun", ALUFun, 6'b110001);
        chk("bne_pcwrite", PCWrite, 0);
        adv();
        adv();

        // sltu then slti
        issue("sltu", rtype(5'd1, 5'd2, 5'd4, 6'h2B));
        to_exec("sltu");
        smp();
        chk("sltu_alufun", ALUFun, 6'b110101);
        chk("sltu_sign", Sign, 0);
        chk("sltu_srcb", ALUSrcB, 0);
        adv();
        adv();
        issue("slti", itype(6'h0A, 5'd1, 5'd4, 16'd5));
        to_exec("slti");
        smp();
        chk("slti_alufun", ALUFun, 6'b110101);
        chk("slti_sign", Sign, 1);
        chk("slti_srcb", ALUSrcB, 1);
        adv();
        adv();

        // lui $7,0x1234
        issue("lui", itype(6'h0F, 5'd0, 5'd7, 16'h1234));
        to_exec("lui");
        smp();
        chk("lui_alufun", ALUFun, 6'b100000);
        chk("lui_srca", ALUSrcA, 2);
        chk("lui_srcb", ALUSrcB, 2);
        adv();
        smp();
        chk("lui_wb_regwrite", RegWrite, 1);
        chk("lui_wb_regdst", RegDst, 0);
        adv();

        // add $0,$1,$2: write to $0 suppressed
        issue("add0", rtype(5'd1, 5'd2, 5'd0, 6'h20));
        to_exec("add0");
        adv();
        smp();
        chk("add0_wb_regwrite", RegWrite, 0);
        adv();

        // bltz with alu_z0=1
        alu_z0 = 1'b1;
        issue("bltz", itype(6'h01, 5'd3, 5'd0, 16'd2));
        to_exec("bltz");
        smp();
        chk("bltz_alufun", ALUFun, 6'b111011);
        chk("bltz_srcb", ALUSrcB, 3);
        chk("bltz_pcwrite", PCWrite, 1);
        adv();
        alu_z0 = 1'b0;
        adv();

        // jal then jr $31
        issue("jal", {6'h03, 26'd64});
        to_exec("jal");
        smp();
        chk("jal_pcwrite", PCWrite, 1);
        chk("jal_pcsrc", PCSrc, 1);
        adv();
        smp();
        chk("jal_wb_regwrite", RegWrite, 1);
        chk("jal_wb_regdst", RegDst, 2);
        chk("jal_wb_memtoreg", MemtoReg, 2);
        chk("jal_wb_pcwrite", PCWrite, 0);
        adv();
        issue("jr", rtype(5'd31, 5'd0, 5'd0, 6'h08));
        to_exec("jr");
        smp();
        chk("jr_pcwrite", PCWrite, 1);
        chk("jr_pcsrc", PCSrc, 2);
        adv();
        smp();
        chk("jr_after_ready", instr_ready, 1);
        chk("jr_after_regwrite", RegWrite, 0);
        adv();

        // sw with mem_ready in the first MEM cycle
        issue("swf", itype(6'h2B, 5'd1, 5'd5, 16'd0));
        to_exec("swf");
        adv();
        mem_ready = 1'b1;
        smp();
        chk("swf_memwrite", MemWrite, 1);
        adv();
        mem_ready = 1'b0;
        smp();
        chk("swf_after_ready", instr_ready, 1);
        chk("swf_after_memwrite", MemWrite, 0);
        adv();

        // reset during a lw MEM wait, coincident with mem_ready
        issue("lwr", itype(6'h23, 5'd1, 5'd6, 16'd8));
        to_exec("lwr");
        adv();
        adv();
        reset     = 1'b1;
        mem_ready = 1'b1;
        smp();
        chk("lwr_mem_memread", MemRead, 1);
        adv();
        reset     = 1'b0;
        mem_ready = 1'b0;
        smp();
        chk("lwr_rst_ready", instr_ready, 1);
        chk("lwr_rst_memread", MemRead, 0);
        chk("lwr_rst_fault", fault, 0);
        chk("lwr_rst_regwrite", RegWrite, 0);
        adv();

        // sw with mem_ready never asserted: 16 MEM cycles then FAULT
        issue("swt", itype(6'h2B, 5'd1, 5'd5, 16'd0));
        to_exec("swt");
        adv();
        for (int i = 0; i < 16; i++) begin
            smp();
            chk("swt_mem_memwrite", MemWrite, 1);
            chk("swt_mem_fault", fault, 0);
            adv();
        end
        smp();
        chk("swt_fault", fault, 1);
        chk("swt_fault_ready", instr_ready, 0);
        chk("swt_fault_memwrite", MemWrite, 0);
        instr_valid = 1'b1;
        instr       = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        repeat (3) adv();
        smp();
        chk("swt_fault_sticky", fault, 1);
        chk("swt_fault_sticky_ready", instr_ready, 0);
        chk("swt_fault_regwrite", RegWrite, 0);
        instr_valid = 1'b0;
        reset       = 1'b1;
        adv();
        reset = 1'b0;
        smp();
        chk("swt_rst_fault", fault, 0);
        chk("swt_rst_ready", instr_ready, 1);
        adv();

        // illegal opcode, then illegal funct
        issue("ill", 32'hFC00_0000);
        adv();
        smp();
        chk("ill_fault", fault, 1);
        chk("ill_ready", instr_ready, 0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        smp();
        chk("ill_rst_fault", fault, 0);
        adv();
        issue("illf", rtype(5'd1, 5'd2, 5'd3, 6'h3F));
        adv();
        smp();
        chk("illf_fault", fault, 1);
        chk("illf_alufun", ALUFun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum number of MEM-state cycles spent waiting for mem_ready.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port instr_valid  in  1  instruction offered.
REQ-005 SHALL have port instr_ready  out  1  block can accept an instruction.
REQ-006 SHALL have port instr  in  32  MIPS instruction word, sampled on handshake.
REQ-007 SHALL have port mem_ready  in  1  data memory access complete.
REQ-008 SHALL have port alu_z0  in  1  bit 0 of the ALU result, used for branch decision.
REQ-009 SHALL have port ALUFun  out  6  ALU operation code.
REQ-010 SHALL have port Sign  out  1  signed (1) or unsigned (0) compare.
REQ-011 SHALL have port ALUSrcA  out  2  operand A select: 0=rs, 1=shamt, 2=const 16.
REQ-012 SHALL have port ALUSrcB  out  2  operand B select: 0=rt, 1=sign-extended imm, 2=zero-extended imm, 3=zero.
REQ-013 SHALL have port RegWrite/MemRead/MemWrite/PCWrite  out  1 each  strobes.
REQ-014 SHALL have port RegDst  out  2  write destination: 0=rt, 1=rd, 2=$31.
REQ-015 SHALL have port MemtoReg  out  2  write-back source: 0=ALU, 1=mem, 2=PC+4.
REQ-016 SHALL have port PCSrc  out  2  next-PC source: 0=branch target, 1=jump target, 2=rs.
REQ-017 SHALL have port fault  out  1  sticky flag: illegal opcode or memory timeout.

Function
REQ-018 SHALL implement an FSM with states IDLE, DECODE, EXEC, MEM, WB and FAULT.
REQ-019 SHALL assert instr_ready only in IDLE; a handshake (instr_valid&&instr_ready) latches instr and moves the FSM to DECODE.
REQ-020 DECODE SHALL register all ALU and datapath selects; an unsupported opcode or funct SHALL move the FSM to FAULT.
REQ-021 ALUFun SHALL use these encodings: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-022 The supported instruction set and mappings SHALL be:
- add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr.
- addi/addiu/andi/slti/sltiu/lui/lw/sw/beq/bne/blez/bgtz/bltz/j/jal.
- Sign=0 for the unsigned forms (addu, subu, sltu, addiu, sltiu); Sign=1 otherwise.
- lui = SLL with ALUSrcA=2 and ALUSrcB=2.
- blez/bgtz/bltz SHALL use ALUSrcB=3.
REQ-023 EXEC SHALL hold ALUFun, Sign and the operand selects stable for exactly one cycle.
REQ-024 For branches, PCWrite SHALL be pulsed in the EXEC cycle iff alu_z0=1, with PCSrc=0.
REQ-025 For j and jr, PCWrite SHALL be pulsed in EXEC with PCSrc=1 (j) or 2 (jr); jal SHALL additionally go to WB with RegDst=2 and MemtoReg=2.
REQ-026 R-type and immediate ALU instructions SHALL follow EXEC -> WB; RegWrite SHALL be high for exactly the single WB cycle; WB SHALL then return to IDLE.
REQ-027 lw SHALL follow EXEC -> MEM; MemRead SHALL be held until mem_ready, then the FSM SHALL go to WB with MemtoReg=1.
REQ-028 sw SHALL follow EXEC -> MEM; MemWrite SHALL be held until mem_ready, then the FSM SHALL return to IDLE.
REQ-029 mem_ready in the first MEM cycle SHALL complete the access in that cycle.
REQ-030 If mem_ready has not arrived after MEM_TIMEOUT cycles in MEM, the FSM SHALL go to FAULT; the wait counter SHALL saturate and SHALL clear on entry to MEM.
REQ-031 A write to $0 (decoded destination 0) SHALL suppress RegWrite.
REQ-032 In FAULT all strobes SHALL be 0, instr_ready=0 and fault=1; only reset SHALL exit FAULT.
REQ-033 Strobes SHALL never be asserted outside the state named for them.

Reset
REQ-034 Reset SHALL force state=IDLE, every output=0 except instr_ready=1, fault=0, and the wait counter=0.
REQ-035 Reset SHALL take priority over every other event in the same cycle, including a handshake or mem_ready, and SHALL abort an in-flight MEM access with no strobe in the following cycle.

Structure
REQ-036 The ALUFun encodings, state enum and opcode/funct constants SHALL reside in a shared package, mips_ctrl_pkg, reused by the ALU and datapath.
REQ-037 The combinational instruction-to-control mapping SHALL be one sub-module, ctrl_decode; the FSM and timeout counter SHALL remain in multicycle_ctrl.

Verification
REQ-038 add $3,$1,$2: handshake at cycle 0 -> ALUFun=000000 and Sign=1 in cycle 2; RegWrite=1 and RegDst=1 in cycle 3 only; instr_ready=1 in cycle 4.
REQ-039 lw with mem_ready delayed 3 cycles -> MemRead high for 4 cycles, then one WB cycle with MemtoReg=1.
REQ-040 beq with alu_z0=1, then bne with alu_z0=0 -> ALUFun 110011 with PCWrite=1 and PCSrc=0; then ALUFun 110001 with PCWrite=0.
REQ-041 sltu then slti -> ALUFun=110101 for both; Sign=0 then Sign=1; ALUSrcB=0 then 1.
REQ-042 sw with mem_ready never asserted, MEM_TIMEOUT=16 -> FAULT entered after 16 MEM cycles; fault=1 and instr_ready=0 until reset.
REQ-043 Reset asserted in the middle of a lw MEM wait -> next cycle state=IDLE, MemRead=0, instr_ready=1, fault=0.
